// File: rtl/fm_seq_pkg.sv
// Shared types and constants for the fundamental-mode stimulus sequencer.
package fm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_SETTLE,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    localparam int X1_IDX = 0;
    localparam int X2_IDX = 1;
    localparam int Z1_IDX = 0;
    localparam int Z2_IDX = 1;

    // Lower bound keeps every sample behind the 2-flop synchronizer latency.
    localparam int SETTLE_MIN = 3;
    localparam int SETTLE_MAX = 255;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] z_exp;
    } cmd_t;

    // One-hot of the lowest set bit: X1 moves before X2.
    function automatic logic [1:0] lowest_bit(input logic [1:0] d);
        logic [1:0] r;
        r = 2'b00;
        if (d[X1_IDX])      r[X1_IDX] = 1'b1;
        else if (d[X2_IDX]) r[X2_IDX] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fm_stimulus_sequencer_if.sv
// Command and response handshake bundle between host and sequencer.
interface fm_stimulus_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_x;
    logic [1:0] cmd_z_exp;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_z;
    logic       rsp_match;

    modport master (
        output cmd_valid, cmd_x, cmd_z_exp, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_z, rsp_match
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_z_exp, rsp_ready,
        output cmd_ready, rsp_valid, rsp_z, rsp_match
    );
endinterface

// File: rtl/fm_stimulus_sequencer_sync2.sv
// Free-running two-flop synchronizer, async active-high reset to zero.
module sync2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/fm_stimulus_sequencer.sv
// Walks X1/X2 toward a commanded target one bit at a time, waits out a settle
// interval per change, then samples synchronized Z1/Z2 and reports the result.
module fm_stimulus_sequencer #(
    parameter int SETTLE_CYCLES = 8,
    parameter int ERR_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    fm_stimulus_sequencer_if.slave  bus,
    output logic [1:0]              x_out,
    input  logic [1:0]              z_in,
    output logic                    busy,
    output logic [ERR_W-1:0]        err_count
);
    import fm_seq_pkg::*;

    if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 3..255");
    end

    state_t     state;
    cmd_t       cmd_q;
    logic [7:0] cnt;
    logic [1:0] z_sync;
    logic [1:0] diff;
    logic [1:0] rsp_z_q;
    logic       rsp_match_q;

    sync2 #(.W(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (z_in),
        .q   (z_sync)
    );

    assign diff = x_out ^ cmd_q.x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            cnt         <= '0;
            x_out       <= 2'b00;
            rsp_z_q     <= 2'b00;
            rsp_match_q <= 1'b0;
            err_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q.x     <= bus.cmd_x;
                        cmd_q.z_exp <= bus.cmd_z_exp;
                        state       <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (diff == 2'b00) begin
                        state <= ST_SAMPLE;
                    end else begin
                        // Only one input may move per edge to stay in fundamental mode.
                        x_out <= x_out ^ lowest_bit(diff);
                        cnt   <= 8'(SETTLE_CYCLES - 1);
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 8'd0) state <= ST_STEP;
                    else             cnt   <= cnt - 8'd1;
                end
                ST_SAMPLE: begin
                    rsp_z_q     <= z_sync;
                    rsp_match_q <= (z_sync == cmd_q.z_exp);
                    if (z_sync != cmd_q.z_exp && err_count != {ERR_W{1'b1}})
                        err_count <= err_count + 1'b1;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_match = rsp_match_q;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_fm_stimulus_sequencer.sv
// Scoreboard bench for fm_stimulus_sequencer driving a 2-clock-delay circuit model.
module tb_fm_stimulus_sequencer;
    localparam int S     = 4;
    localparam int ERR_W = 8;

    typedef struct {
        logic [1:0] z;
        logic       m;
        int         lat;
    } exp_t;

    typedef struct {
        int         c;
        logic [1:0] v;
    } chg_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       x_out;
    logic [1:0]       z_in;
    logic             busy;
    logic [ERR_W-1:0] err_count;

    fm_stimulus_sequencer_if itf();

    fm_stimulus_sequencer #(.SETTLE_CYCLES(S), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (itf),
        .x_out     (x_out),
        .z_in      (z_in),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Circuit model: Z1 = X1^X2, Z2 = X1&X2, two clocks of propagation delay.
    function automatic logic [1:0] zf(input logic [1:0] x);
        return {x[0] & x[1], x[0] ^ x[1]};
    endfunction

    logic [1:0] zd1 = 2'b00, zd2 = 2'b00;
    logic       force_en = 1'b0, glitch_en = 1'b0;
    logic [1:0] force_val = 2'b00, glitch_val = 2'b00;
    always @(posedge clk) begin
        zd1 <= zf(x_out);
        zd2 <= zd1;
    end
    assign z_in = glitch_en ? glitch_val : (force_en ? force_val : zd2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    exp_t       sb_q[$];
    chg_t       chg_q[$];
    logic [1:0] x_model = 2'b00;
    int         exp_err = 0;

    // x_out change monitor: single-input-change and minimum hold between changes.
    logic [1:0] x_prev = 2'b00;
    int         last_chg = 0;
    bit         have_chg = 0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            have_chg = 0;
        end else if (x_out !== x_prev) begin
            chk("sic", $countones(x_out ^ x_prev), 1);
            if (have_chg) chk("hold_min", ((cyc - last_chg) >= S + 1) ? 1 : 0, 1);
            chg_q.push_back('{c: cyc, v: x_out});
            last_chg = cyc;
            have_chg = 1;
        end
        x_prev = x_out;
    end

    task automatic accept(output int e0, output bit ok);
        ok = 0;
        e0 = 0;
        itf.cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (itf.cmd_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
            e0 = cyc;
        end else begin
            chk("accept_timeout", 0, 1);
        end
        itf.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] x, input logic [1:0] zexp,
                           input int hold, input bit glitch, output int e0);
        exp_t e, p;
        bit   ok, seen;
        int   k;
        logic [1:0] hz;
        logic       hm;
        e.z   = force_en ? force_val : zf(x);
        e.m   = (e.z == zexp);
        k     = $countones(x_model ^ x);
        e.lat = 2 + k * (S + 1);
        sb_q.push_back(e);
        itf.cmd_x     = x;
        itf.cmd_z_exp = zexp;
        accept(e0, ok);
        if (!ok) return;
        x_model = x;
        if (glitch) begin
            // Pulse a wrong value across the edge right after acceptance only.
            glitch_val = ~e.z;
            #8 glitch_en = 1'b1;
            #2 glitch_en = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (itf.rsp_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        p = sb_q.pop_front();
        if (!p.m && exp_err < (1 << ERR_W) - 1) exp_err++;
        chk("latency", cyc - e0, p.lat);
        chk("rsp_z", itf.rsp_z, p.z);
        chk("rsp_match", itf.rsp_match, p.m);
        chk("err_count", err_count, exp_err);
        chk("x_out", x_out, x);
        hz = itf.rsp_z;
        hm = itf.rsp_match;
        itf.cmd_x = ~x;
        if (hold > 0) itf.cmd_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", itf.rsp_valid, 1);
            chk("hold_rsp_z", itf.rsp_z, hz);
            chk("hold_rsp_match", itf.rsp_match, hm);
            chk("hold_cmd_ready", itf.cmd_ready, 0);
            chk("hold_x_out", x_out, x);
        end
        itf.cmd_valid = 1'b0;
        itf.rsp_ready = 1'b1;
        @(posedge clk); #1;
        itf.rsp_ready = 1'b0;
        chk("post_rsp_valid", itf.rsp_valid, 0);
        chk("post_cmd_ready", itf.cmd_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        int  e0;
        bit  ok;
        itf.cmd_valid = 1'b0;
        itf.cmd_x     = 2'b00;
        itf.cmd_z_exp = 2'b00;
        itf.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_out", x_out, 0);
        chk("rst_rsp_valid", itf.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        #4 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_cmd_ready", itf.cmd_ready, 1);
        chk("rst_err_count", err_count, 0);
        chk("rst_rsp_z", itf.rsp_z, 0);
        chk("rst_rsp_match", itf.rsp_match, 0);

        // k=0 command
        run_cmd(2'b00, 2'b00, 0, 0, e0);
        chk("t1_no_x_change", chg_q.size(), 0);

        // 00 -> 11: X1 at E0+1, X2 at E0+6
        chg_q.delete();
        run_cmd(2'b11, zf(2'b11), 0, 0, e0);
        chk("t2_changes", chg_q.size(), 2);
        if (chg_q.size() == 2) begin
            chk("t2_first_cyc", chg_q[0].c - e0, 1);
            chk("t2_first_val", chg_q[0].v, 2'b01);
            chk("t2_second_cyc", chg_q[1].c - e0, 6);
            chk("t2_second_val", chg_q[1].v, 2'b11);
        end
        run_cmd(2'b10, zf(2'b10), 0, 0, e0);
        run_cmd(2'b01, 2'b11, 0, 0, e0);

        // Forced mismatch, then saturation of err_count
        force_en  = 1'b1;
        force_val = 2'b10;
        repeat (6) @(posedge clk);
        #1;
        run_cmd(x_model, 2'b01, 0, 0, e0);
        for (int i = 0; i < 300; i++) run_cmd(x_model, 2'b01, 0, 0, e0);
        chk("t3_saturated", err_count, 255);
        force_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Back-pressured response with a competing command
        run_cmd(2'b00, zf(2'b00), 10, 0, e0);

        // Reset during SETTLE
        itf.cmd_x     = 2'b11;
        itf.cmd_z_exp = 2'b00;
        accept(e0, ok);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_mid_settle_x", x_out, 2'b01);
        chk("t5_mid_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_x_out", x_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rsp_valid", itf.rsp_valid, 0);
        chk("t5_rst_err", err_count, 0);
        @(posedge clk);
        #5 rst = 1'b0;
        x_model = 2'b00;
        exp_err = 0;
        @(posedge clk); #1;
        chk("t5_cmd_ready", itf.cmd_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chg_q.delete();
        run_cmd(2'b10, zf(2'b10), 0, 0, e0);
        chk("t5_restart_chg", chg_q.size(), 1);
        if (chg_q.size() == 1) chk("t5_restart_first", chg_q[0].c - e0, 1);

        // z_in glitch across the edge right before the sample point
        repeat (4) @(posedge clk);
        #1;
        run_cmd(2'b10, zf(2'b10), 0, 1, e0);
        run_cmd(2'b11, zf(2'b11), 0, 0, e0);
        repeat (6) @(posedge clk);
        #1;
        run_cmd(2'b11, zf(2'b11), 0, 1, e0);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
